// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop input sync, mid-bit sampling, one-cycle valid / framing-error strobes.
// Define UART_RX_MAJORITY_EN to decide every bit by a 3-sample majority vote around its mid-point.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       in_Clk,
    input  logic       in_Reset,
    input  logic       in_RX_Serial,
    output logic [7:0] out_RX_Byte,
    output logic       out_RX_Valid,
    output logic       out_RX_Active,
    output logic       out_RX_Frame_Err
);

    localparam int CW  = $clog2(CLKS_PER_BIT) + 1;
    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // The IDLE detect cycle counts as tick 0, so the vote at mid+1 lands on the
    // same clock as the single-sample decision and latency does not move.
    localparam logic [CW-1:0] START_CNT0 = CW'(1);
    localparam logic [CW-1:0] START_END  = CW'(MID + 1);
`else
    localparam logic [CW-1:0] START_CNT0 = '0;
    localparam logic [CW-1:0] START_END  = CW'(MID);
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        CLEAN    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            active_q, active_d;
    logic            meta_q, line_q;
    logic            bit_val;

    always_ff @(posedge in_Clk) begin
        if (!in_Reset) begin
            meta_q <= 1'b1;
            line_q <= 1'b1;
        end else begin
            meta_q <= in_RX_Serial;
            line_q <= meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] holds the line one cycle back (mid), hist_q[1] two back (mid-1).
    logic [1:0] hist_q;
    always_ff @(posedge in_Clk) begin
        if (!in_Reset) hist_q <= 2'b11;
        else           hist_q <= {hist_q[0], line_q};
    end
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & line_q) | (hist_q[0] & line_q);
`else
    assign bit_val = line_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!line_q) begin
                    state_d  = RX_START;
                    cnt_d    = START_CNT0;
                    active_d = 1'b1;
                end
            end
            RX_START: begin
                if (cnt_q < START_END) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!bit_val) begin
                    cnt_d   = '0;
                    state_d = RX_DATA;
                end else begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    active_d = 1'b0;
                end
            end
            RX_DATA: begin
                if (cnt_q < BIT_END) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d          = '0;
                    shift_d[idx_q] = bit_val;
                    if (idx_q < 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        idx_d   = '0;
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q < BIT_END) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = CLEAN;
                    if (bit_val) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            CLEAN: begin
                cnt_d    = '0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge in_Clk) begin
        if (!in_Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
        end
    end

    assign out_RX_Byte      = byte_q;
    assign out_RX_Valid     = valid_q;
    assign out_RX_Active    = active_q;
    assign out_RX_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core; expected bytes come from a frame-level queue model.
module tb_uart_rx_core;

    localparam int CPB = 87;
    localparam int MID = (CPB - 1) / 2;
    localparam int LAT = 2 + MID + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rbyte;
    logic       rvalid, ractive, rferr;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
        .in_Clk          (clk),
        .in_Reset        (rst_n),
        .in_RX_Serial    (rx),
        .out_RX_Byte     (rbyte),
        .out_RX_Valid    (rvalid),
        .out_RX_Active   (ractive),
        .out_RX_Frame_Err(rferr)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         ferr_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       prev_pulse = 1'b0;
    time        vtime = 0;
    time        last_t0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: collects received bytes and frame errors.
    always @(negedge clk) begin
        if (rvalid) begin
            got_q.push_back(rbyte);
            vtime = $time;
        end
        if (rferr) ferr_cnt++;
        if (rvalid || rferr) begin
            chk("valid_ferr_exclusive", {31'd0, rvalid & rferr}, 32'd0);
            chk("pulse_one_cycle", {31'd0, prev_pulse}, 32'd0);
        end
        prev_pulse = rvalid | rferr;
    end

    // Call right after a posedge; glitch_bit (frame bit index) gets a 1-cycle inversion at its mid-point.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        last_t0 = $time;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            for (int c = 0; c < CPB; c++) begin
                if (i == glitch_bit && c == CPB / 2)     rx = ~bits[i];
                if (i == glitch_bit && c == CPB / 2 + 1) rx = bits[i];
                @(posedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic check_bytes(input string tag);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte"},   rbyte,   32'h00);
        chk({tag, "_valid"},  rvalid,  32'd0);
        chk({tag, "_active"}, ractive, 32'd0);
        chk({tag, "_ferr"},   rferr,   32'd0);
    endtask

    initial begin
        int         bad;
        int         lat;
        int         gap;
        logic [7:0] rb;
        logic [9:0] bits;

        // Reset, then a quiet line for 20 bit periods.
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20 * CPB) begin
            @(negedge clk);
            if (rvalid || rferr || ractive || rbyte != 8'h00) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Single frame with latency check.
        @(posedge clk);
        send_frame(8'hA5, 1'b1, -1);
        exp_q.push_back(8'hA5);
        check_bytes("a5");
        chk("a5_out", rbyte, 32'hA5);
        chk("a5_active_low", ractive, 32'd0);
        lat = int'((vtime - last_t0 - 5) / 10);
        chk("a5_latency_window", {31'd0, (lat >= LAT - 1 && lat <= LAT + 1)}, 32'd1);

        // Back-to-back frames, no idle gap.
        @(posedge clk);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        check_bytes("b2b");
        chk("b2b_no_ferr", ferr_cnt, 0);

        // Stop bit forced low.
        @(posedge clk);
        send_frame(8'h55, 1'b0, -1);
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        chk("ferr_count", ferr_cnt, 1);
        chk("ferr_no_valid", got_q.size(), 0);
        chk("ferr_byte_held", rbyte, 32'h3C);

        // False start: 10 clocks low.
        @(posedge clk);
        rx = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("false_active_high", ractive, 32'd1);
        @(posedge clk);
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
        @(negedge clk);
        chk("false_active_low", ractive, 32'd0);
        chk("false_no_valid", got_q.size(), 0);
        chk("false_no_ferr", ferr_cnt, 1);
        @(posedge clk);
        send_frame(8'h81, 1'b1, -1);
        exp_q.push_back(8'h81);
        check_bytes("after_false");

        // Random bytes with random idle gaps.
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            rb = 8'($urandom);
            exp_q.push_back(rb);
            send_frame(rb, 1'b1, -1);
            gap = $urandom_range(0, CPB);
            repeat (gap) @(posedge clk);
        end
        check_bytes("rand");
        chk("rand_no_ferr", ferr_cnt, 1);

        // Reset during data bit 4 of 8'hC3.
        @(posedge clk);
        rb = 8'hC3;
        bits = {1'b1, rb, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
        end
        rx = bits[5];
        repeat (CPB / 2) @(posedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        @(negedge clk);
        chk("midreset_no_valid", got_q.size(), 0);
        chk("midreset_no_ferr", ferr_cnt, 1);
        @(posedge clk);
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h12, 1'b1, 5);
`else
        send_frame(8'h12, 1'b1, -1);
`endif
        exp_q.push_back(8'h12);
        check_bytes("after_reset");
        chk("after_reset_out", rbyte, 32'h12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
8N1 UART receiver: serial line in, one byte out per frame, with a one-cycle valid strobe. It is the receive end of the same serial link as the UART transmitter in the APB GPIO/UART controller. It feeds the APB RX data register.
- Oversamples at CLKS_PER_BIT clocks per bit and samples each bit at its mid-point.
- Reports framing errors.

Parameters:
- CLKS_PER_BIT, 87, number of in_Clk cycles per bit period (integer, must be >= 4).

Ports:
- in_Clk  input  1  system clock; all logic on the rising edge.
- in_Reset  input  1  synchronous active-low reset, sampled on the rising edge of in_Clk.
- in_RX_Serial  input  1  asynchronous serial line; idles high.
- out_RX_Byte  output  8  last received byte, LSB first on the line; holds until the next frame completes.
- out_RX_Valid  output  1  one-cycle pulse when out_RX_Byte is updated.
- out_RX_Active  output  1  high from detected start edge until return to IDLE.
- out_RX_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (in_Reset low at a clock edge):
  - State goes to IDLE; counters and bit index go to 0.
  - Outputs: out_RX_Byte=8'h00, out_RX_Valid=0, out_RX_Active=0, out_RX_Frame_Err=0.
  - Synchronizer flops are set to 1.
  - Reset applied mid-frame abandons the frame with no valid and no error pulse.
- Input sync: in_RX_Serial passes through 2 flops before use. All references to "line" below mean the synchronized value, which adds 2 cycles of latency.
- Clock counter width is $clog2(CLKS_PER_BIT)+1.
- State machine states:
  - IDLE: counter=0, index=0. A line value of 0 moves to RX_START and sets out_RX_Active=1.
  - RX_START:
    - Count to (CLKS_PER_BIT-1)/2, integer division, to reach the bit mid-point.
    - At the mid-point, line=0 → counter=0, go to RX_DATA.
    - At the mid-point, line=1 → false start: go to IDLE, out_RX_Active=0, no pulses.
  - RX_DATA:
    - Each bit waits CLKS_PER_BIT-1 increments, then samples the line into shift bit [index].
    - index < 7 → index+1; index 7 → index=0, go to RX_STOP.
  - RX_STOP:
    - Wait CLKS_PER_BIT-1 increments, then sample the line.
    - Sample 1: out_RX_Byte <= shift register, out_RX_Valid=1.
    - Sample 0: out_RX_Frame_Err=1, out_RX_Byte unchanged, no valid pulse.
    - Either way go to CLEAN.
  - CLEAN: one cycle; pulses return to 0; out_RX_Active=0; go to IDLE.
  - Any undefined state encoding goes to IDLE.
- Pulse width: out_RX_Valid and out_RX_Frame_Err are high for exactly one cycle and are never high together.
- Back-to-back frames: a start bit arriving while in CLEAN is detected on the first IDLE cycle. At most 1 cycle of lost alignment is acceptable; no frame is dropped.
- Line stuck low: after a frame error, the next frame starts only if the line reads 0 in IDLE (break repeats frame errors). This is accepted behaviour.
- Latency: valid pulse occurs 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the start-bit falling edge at the pin.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- With the macro defined: each data bit and the stop bit are decided by majority vote of three samples, taken at counter values mid-1, mid and mid+1 of that bit. The start-bit check also uses the majority of the same three points. Latency is unchanged; the decision registers at the mid+1 sample.
- Without the macro: a single sample at the mid-point decides each bit, as described above.

Test Plan:
- Reset then idle line: all outputs 0 and out_RX_Byte=8'h00 for 20 bit periods; no pulses.
- Single frame 8'hA5 at CLKS_PER_BIT=87: out_RX_Valid high for 1 cycle, out_RX_Byte=8'hA5, out_RX_Active deasserted in CLEAN.
- Back-to-back frames 8'h00, 8'hFF, 8'h3C with no idle gap: three valid pulses, bytes in order, no frame error.
- Frame 8'h55 with stop bit forced 0: out_RX_Frame_Err pulses once, no valid pulse, out_RX_Byte keeps the prior value.
- False start (line low for 10 clocks then high): returns to IDLE, out_RX_Active falls, no pulses; a following frame 8'h81 is received correctly.
- Reset asserted at data bit 4 of frame 8'hC3: no valid pulse, outputs at reset values; the next frame 8'h12 is received correctly. With UART_RX_MAJORITY_EN defined, a 1-cycle glitch at a bit mid-point of 8'h12 still yields 8'h12.
